// File: rtl/dmem_block_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_block_arbiter
//
// Shares a single 128-bit block-wide data memory between two block
// requesters (e.g. I-cache refill and D-cache refill/writeback). One access
// is granted at a time. The memory is driven for a fixed LATENCY-cycle
// window, then the owning port gets a one-cycle ack. This block is the only
// master of the memory address and write strobe.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins simultaneous
//                                        requests (no round-robin pointer)
//                           undefined -> round-robin between the two ports
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous reset, active high
//   req0_i/req1_i    access request (level, held until ack)
//   we0_i/we1_i      1 = block write, 0 = block read
//   addr0_i/addr1_i  word address, bits [1:0] ignored
//   wdata0_i/1_i     write block
//   ack0_o/ack1_o    one-cycle completion pulse
//   rdata0_o/1_o     read block, valid from the ack cycle until the next read
//   mem_addr_o       memory address, bits [1:0] forced to 0
//   mem_write_o      memory write commit strobe (single cycle per write)
//   mem_wdata_o      memory write block
//   mem_rdata_i      memory read block
//   busy_o           high while an access is in flight (ACCESS or RESP)
//   grant_o          one-hot owner of the current access, 0 when idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; arbitrate between pending requests
// ACCESS | memory driven for LATENCY cycles; commit/capture when cnt==0
// RESP   | ack pulsed to the owner; round-robin pointer updated
// ---------------------------------------------------------------------------
module dmem_block_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int BLK_W   = 128,
   parameter int LATENCY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [BLK_W-1:0]  wdata0_i,
   input  logic [BLK_W-1:0]  wdata1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [BLK_W-1:0]  rdata0_o,
   output logic [BLK_W-1:0]  rdata1_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_write_o,
   output logic [BLK_W-1:0]  mem_wdata_o,
   input  logic [BLK_W-1:0]  mem_rdata_i,
   output logic              busy_o,
   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Counter loads LATENCY-1 so the terminal cycle (cnt==0) is the last
   // ACCESS cycle; LATENCY=1 makes the first ACCESS cycle terminal.
   localparam logic [4:0]        CNT_INIT  = 5'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

   state_t              state_q;
   logic [4:0]          cnt_q;
   logic                port_q;
   logic                we_q;
   logic                ack0_q;
   logic                ack1_q;
   logic [BLK_W-1:0]    rdata0_q;
   logic [BLK_W-1:0]    rdata1_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_write_q;
   logic [BLK_W-1:0]    mem_wdata_q;
   logic                busy_q;
   logic [1:0]          grant_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic                rr_ptr_q;
`endif

   // Arbitration result for the current IDLE cycle.
   logic                port_d;
   logic                we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [BLK_W-1:0]    wdata_d;

   always_comb begin
      port_d = 1'b0;
      if (req0_i && req1_i) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         port_d = 1'b0;
`else
         port_d = rr_ptr_q;
`endif
      end else if (req1_i) begin
         port_d = 1'b1;
      end
      we_d    = port_d ? we1_i    : we0_i;
      addr_d  = (port_d ? addr1_i : addr0_i) & ADDR_MASK;
      wdata_d = port_d ? wdata1_i : wdata0_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_addr_q  <= '0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         grant_q     <= 2'b00;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= 1'b0;
`endif
      end else begin
         // Pulsed outputs default low; only the branches below raise them.
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_write_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0_i || req1_i) begin
                  port_q      <= port_d;
                  we_q        <= we_d;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= wdata_d;
                  cnt_q       <= CNT_INIT;
                  grant_q     <= port_d ? 2'b10 : 2'b01;
                  busy_q      <= 1'b1;
                  // Strobe is registered, so it is raised one edge ahead
                  // of the terminal cycle.
                  mem_write_q <= we_d && (CNT_INIT == 5'd0);
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q == 5'd0) begin
                  if (!we_q) begin
                     if (port_q) rdata1_q <= mem_rdata_i;
                     else        rdata0_q <= mem_rdata_i;
                  end
                  ack0_q  <= ~port_q;
                  ack1_q  <= port_q;
                  state_q <= RESP;
               end else begin
                  cnt_q       <= cnt_q - 5'd1;
                  mem_write_q <= we_q && (cnt_q == 5'd1);
               end
            end
            RESP: begin
               busy_q   <= 1'b0;
               grant_q  <= 2'b00;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               rr_ptr_q <= ~port_q;
`endif
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack0_o      = ack0_q;
   assign ack1_o      = ack1_q;
   assign rdata0_o    = rdata0_q;
   assign rdata1_o    = rdata1_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_write_o = mem_write_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;
   assign grant_o     = grant_q;

endmodule

// File: tb/tb_dmem_block_arbiter.sv
module tb_dmem_block_arbiter;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   // DUT A: LATENCY = 4
   logic         a_req0, a_req1, a_we0, a_we1;
   logic [31:0]  a_addr0, a_addr1;
   logic [127:0] a_wdata0, a_wdata1;
   logic         a_ack0, a_ack1;
   logic [127:0] a_rdata0, a_rdata1;
   logic [31:0]  a_mem_addr;
   logic         a_mem_write;
   logic [127:0] a_mem_wdata, a_mem_rdata;
   logic         a_busy;
   logic [1:0]   a_grant;

   // DUT B: LATENCY = 1
   logic         b_req0;
   logic [31:0]  b_addr0;
   logic         b_ack0, b_ack1;
   logic [127:0] b_rdata0, b_rdata1;
   logic [31:0]  b_mem_addr;
   logic         b_mem_write;
   logic [127:0] b_mem_wdata, b_mem_rdata;
   logic         b_busy;
   logic [1:0]   b_grant;

   logic [127:0] envmem [0:255];   // memory the DUT talks to
   logic [127:0] refmem [0:255];   // reference model contents
   logic         mon_en;

   dmem_block_arbiter #(.ADDR_W(32), .BLK_W(128), .LATENCY(4)) u_dut_a (
      .clk_i(clk), .rst_i(rst),
      .req0_i(a_req0), .req1_i(a_req1), .we0_i(a_we0), .we1_i(a_we1),
      .addr0_i(a_addr0), .addr1_i(a_addr1),
      .wdata0_i(a_wdata0), .wdata1_i(a_wdata1),
      .ack0_o(a_ack0), .ack1_o(a_ack1),
      .rdata0_o(a_rdata0), .rdata1_o(a_rdata1),
      .mem_addr_o(a_mem_addr), .mem_write_o(a_mem_write),
      .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata),
      .busy_o(a_busy), .grant_o(a_grant)
   );

   dmem_block_arbiter #(.ADDR_W(32), .BLK_W(128), .LATENCY(1)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .req0_i(b_req0), .req1_i(1'b0), .we0_i(1'b0), .we1_i(1'b0),
      .addr0_i(b_addr0), .addr1_i(32'h0),
      .wdata0_i(128'h0), .wdata1_i(128'h0),
      .ack0_o(b_ack0), .ack1_o(b_ack1),
      .rdata0_o(b_rdata0), .rdata1_o(b_rdata1),
      .mem_addr_o(b_mem_addr), .mem_write_o(b_mem_write),
      .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
      .busy_o(b_busy), .grant_o(b_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] pat_b(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5A5A5A5A, 32'hC0DE0000 | a};
   endfunction

   assign a_mem_rdata = envmem[a_mem_addr[9:2]];
   assign b_mem_rdata = pat_b(b_mem_addr);

   always @(posedge clk) begin
      if (a_mem_write) envmem[a_mem_addr[9:2]] <= a_mem_wdata;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Protocol invariants on both instances, every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("a_write_outside_access", a_mem_write && !(a_busy && !a_ack0 && !a_ack1), 0);
         chk("a_both_acks", a_ack0 && a_ack1, 0);
         chk("b_write_outside_access", b_mem_write && !(b_busy && !b_ack0 && !b_ack1), 0);
         chk("b_both_acks", b_ack0 && b_ack1, 0);
      end
   end

   // Single access on DUT A, started at a negedge while the DUT is idle.
   // n counts negedges after the sampling edge T: n=k is cycle T+k.
   task automatic access_a(input int port, input logic we, input logic [31:0] addr,
                           input logic [127:0] wd, output int ack_n, output int wr_cnt,
                           output int wr_n, output logic [31:0] addr_n1,
                           output logic [127:0] rd);
      ack_n = -1; wr_cnt = 0; wr_n = -1; addr_n1 = 'x; rd = 'x;
      if (port == 0) begin a_req0 = 1; a_we0 = we; a_addr0 = addr; a_wdata0 = wd; end
      else           begin a_req1 = 1; a_we1 = we; a_addr1 = addr; a_wdata1 = wd; end
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) addr_n1 = a_mem_addr;
         if (a_mem_write) begin wr_cnt++; wr_n = n; end
         if ((port == 0) ? a_ack0 : a_ack1) begin
            ack_n = n;
            rd = (port == 0) ? a_rdata0 : a_rdata1;
            break;
         end
      end
      a_req0 = 0; a_req1 = 0;
      @(negedge clk);
   endtask

   int           ack_n, wr_cnt, wr_n, n1, n2;
   logic [31:0]  addr_n1;
   logic [127:0] rd, wd;
   logic [1:0]   g3;
   logic [1:0]   grants [4];
   int           ng;
   logic [1:0]   prev_g;
   logic         model_rr;

   initial begin
      n_chk = 0; n_err = 0; mon_en = 0;
      for (int i = 0; i < 256; i++) begin
         envmem[i] = {32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4)};
         refmem[i] = envmem[i];
      end
      a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0;
      a_addr0 = 0; a_addr1 = 0; a_wdata0 = 0; a_wdata1 = 0;
      b_req0 = 0; b_addr0 = 0;
      rst = 1;
      repeat (3) @(negedge clk);
      mon_en = 1;

      // Reset state
      chk("rst_ack0", a_ack0, 0);
      chk("rst_ack1", a_ack1, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_grant", a_grant, 0);
      chk("rst_mem_write", a_mem_write, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_rdata0", a_rdata0, 0);
      rst = 0;

      // 1: port 0 read of word address 3
      access_a(0, 0, 32'h3, 0, ack_n, wr_cnt, wr_n, addr_n1, rd);
      chk("t1_mem_addr", addr_n1, 32'h0);
      chk("t1_ack_cycle", ack_n, 5);
      chk("t1_rdata", rd, refmem[0]);
      chk("t1_no_write", wr_cnt, 0);

      // 2: port 1 write to 0x10, then port 0 reads it back
      wd = 128'hDEAD0000_11112222_33334444_0000BEEF;
      access_a(1, 1, 32'h10, wd, ack_n, wr_cnt, wr_n, addr_n1, rd);
      refmem[4] = wd;
      chk("t2_wr_count", wr_cnt, 1);
      chk("t2_wr_cycle", wr_n, 4);
      chk("t2_wr_addr", addr_n1, 32'h10);
      chk("t2_ack_cycle", ack_n, 5);
      access_a(0, 0, 32'h10, 0, ack_n, wr_cnt, wr_n, addr_n1, rd);
      chk("t2_readback", rd, wd);
      chk("t2_read_ack", ack_n, 5);

      // 4: reset in the 2nd ACCESS cycle of a write (last served was port 0)
      a_req1 = 1; a_we1 = 1; a_addr1 = 32'h20; a_wdata1 = {4{32'hBAD0BAD0}};
      @(negedge clk);
      @(negedge clk);
      rst = 1; a_req1 = 0;
      @(negedge clk);
      chk("t4_busy", a_busy, 0);
      chk("t4_ack1", a_ack1, 0);
      chk("t4_mem_write", a_mem_write, 0);
      chk("t4_grant", a_grant, 0);
      rst = 0;
      @(negedge clk);
      chk("t4_mem_untouched", envmem[8], refmem[8]);
      a_req0 = 1; a_we0 = 0; a_addr0 = 32'h40;
      a_req1 = 1; a_we1 = 0; a_addr1 = 32'h80;
      @(negedge clk);
      chk("t4_next_grant", a_grant, 2'b01);

      // 3: both requests held from reset
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      ng = 0; prev_g = 0;
      for (int n = 0; n < 60 && ng < 4; n++) begin
         @(negedge clk);
         if (a_grant != 0 && prev_g == 0) begin grants[ng] = a_grant; ng++; end
         prev_g = a_grant;
      end
      chk("t3_grant_count", ng, 4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) chk("t3_fixed_grant", grants[i], 2'b01);
`else
      for (int i = 0; i < 4; i++) chk("t3_rr_grant", grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
      a_req0 = 0; a_req1 = 0;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;

      // 5: LATENCY=1, held request is regranted after one IDLE cycle
      b_req0 = 1; b_addr0 = 32'h44;
      n1 = -1; n2 = -1; g3 = 2'bxx; rd = 'x;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 3) g3 = b_grant;
         if (b_ack0) begin
            if (n1 < 0) begin n1 = n; rd = b_rdata0; end
            else begin n2 = n; break; end
         end
      end
      b_req0 = 0;
      @(negedge clk);
      chk("t5_first_ack", n1, 2);
      chk("t5_rdata", rd, pat_b(32'h44));
      chk("t5_idle_gap", g3, 0);
      chk("t5_second_ack", n2, 5);

      // 6: random traffic against the reference memory
      model_rr = 0;
      for (int r = 0; r < 60; r++) begin
         logic         en [2];
         logic         we [2];
         logic [31:0]  ad [2];
         logic [127:0] dt [2];
         logic         pend [2];
         int           acks [2];
         int           first_port, exp_first;
         for (int p = 0; p < 2; p++) begin
            en[p] = 1'($urandom_range(0, 1));
            we[p] = 1'($urandom_range(0, 1));
            ad[p] = 32'($urandom_range(0, 1023));
            dt[p] = {$urandom, $urandom, $urandom, $urandom};
            acks[p] = 0;
         end
         if (!en[0] && !en[1]) en[0] = 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
         exp_first = en[0] ? 0 : 1;
`else
         exp_first = (en[0] && en[1]) ? int'(model_rr) : (en[0] ? 0 : 1);
`endif
         first_port = -1;
         pend[0] = en[0]; pend[1] = en[1];
         a_req0 = en[0]; a_we0 = we[0]; a_addr0 = ad[0]; a_wdata0 = dt[0];
         a_req1 = en[1]; a_we1 = we[1]; a_addr1 = ad[1]; a_wdata1 = dt[1];
         for (int n = 0; n < 40 && (pend[0] || pend[1]); n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
               if ((p == 0) ? a_ack0 : a_ack1) begin
                  acks[p]++;
                  if (first_port < 0) first_port = p;
                  if (pend[p]) begin
                     if (we[p]) refmem[ad[p][9:2]] = dt[p];
                     else chk("rnd_rdata", (p == 0) ? a_rdata0 : a_rdata1, refmem[ad[p][9:2]]);
                     model_rr = (p == 0);
                  end
                  pend[p] = 0;
                  if (p == 0) a_req0 = 0; else a_req1 = 0;
               end
            end
         end
         a_req0 = 0; a_req1 = 0;
         @(negedge clk);
         chk("rnd_acks0", acks[0], en[0] ? 1 : 0);
         chk("rnd_acks1", acks[1], en[1] ? 1 : 0);
         chk("rnd_first_port", first_port, exp_first);
      end

      // Final memory image must match the model
      for (int i = 0; i < 256; i += 17) chk("final_mem", envmem[i], refmem[i]);

      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
